handshake_fifo_receiver: RTL and testbench

- Elastic receiving buffer for the dataflow handshake protocol: valid/ready channel in, valid/ready channel out.
- Sits on the consumer side of token producers such as the constant and arithmetic units, and absorbs back-pressure from downstream operators.
- Non-transparent FIFO with a registered output and a 1-cycle minimum latency. It breaks both the valid and ready combinational paths from the producer.

---
 rtl/handshake_fifo_receiver_if.sv | 30 +++
 rtl/handshake_fifo_receiver.sv | 78 +++++++
 tb/tb_handshake_fifo_receiver.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/handshake_fifo_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | handshake_fifo_receiver_if : valid/ready in + out channels and occupancy  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface handshake_fifo_receiver_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  logic [DATA_WIDTH-1:0]        ins;
  logic                         ins_valid;
  logic                         ins_ready;
  logic [DATA_WIDTH-1:0]        outs;
  logic                         outs_valid;
  logic                         outs_ready;
  logic [$clog2(DEPTH+1)-1:0]   count;

  // FIFO side
  modport slave (
    input  ins, ins_valid, outs_ready,
    output ins_ready, outs, outs_valid, count
  );

  // Producer/consumer side
  modport master (
    output ins, ins_valid, outs_ready,
    input  ins_ready, outs, outs_valid, count
  );
endinterface
`default_nettype wire

// File: rtl/handshake_fifo_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | handshake_fifo_receiver : registered-output elastic FIFO, 1-cycle latency |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module handshake_fifo_receiver #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  handshake_fifo_receiver_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  released_q, released_d;
  logic                  ins_ready_w, outs_valid_w, push_w, pop_w;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Both handshake outputs come from registered state only.
  assign ins_ready_w  = (count_q != CW'(DEPTH)) & released_q;
  assign outs_valid_w = (count_q != '0);
  assign push_w       = bus.ins_valid & ins_ready_w;
  assign pop_w        = outs_valid_w & bus.outs_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    released_d = 1'b1;
    if (push_w) begin
      mem_d[wr_ptr_q] = bus.ins;
      wr_ptr_d        = bump(wr_ptr_q);
    end
    if (pop_w) begin
      rd_ptr_d = bump(rd_ptr_q);
    end
    if (push_w && !pop_w) begin
      count_d = count_q + CW'(1);
    end else if (pop_w && !push_w) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      released_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      released_q <= released_d;
    end
  end

  assign bus.ins_ready  = ins_ready_w;
  assign bus.outs_valid = outs_valid_w;
  assign bus.outs       = mem_q[rd_ptr_q];
  assign bus.count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_handshake_fifo_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_handshake_fifo_receiver : scoreboard bench, DEPTH=4 directed + DEPTH=3 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_handshake_fifo_receiver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  handshake_fifo_receiver_if #(.DATA_WIDTH(32), .DEPTH(4)) if4 ();
  handshake_fifo_receiver_if #(.DATA_WIDTH(32), .DEPTH(3)) if3 ();

  handshake_fifo_receiver #(.DATA_WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk (clk), .rst (rst), .bus (if4)
  );
  handshake_fifo_receiver #(.DATA_WIDTH(32), .DEPTH(3)) u_dut3 (
    .clk (clk), .rst (rst), .bus (if3)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] q4 [$];
  logic [31:0] m3_q [$];
  int          m3_cnt = 0;
  bit          stress_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // DEPTH=4 monitor: every accepted head token must match the next expected one.
  always @(negedge clk) begin
    if (rst && if4.outs_valid && if4.outs_ready) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dut4_unexpected_pop: got %0h expected none", if4.outs);
      end else begin
        check("dut4_outs", if4.outs, q4.pop_front());
      end
    end
  end

  // DEPTH=3 reference model; decides acceptance from its own occupancy.
  always @(negedge clk) begin
    bit ex_rdy, ex_val, do_push, do_pop;
    if (stress_on) begin
      ex_rdy = (m3_cnt != 3);
      ex_val = (m3_cnt != 0);
      check("dut3_ins_ready", {31'd0, if3.ins_ready}, {31'd0, ex_rdy});
      check("dut3_outs_valid", {31'd0, if3.outs_valid}, {31'd0, ex_val});
      check("dut3_count", {30'd0, if3.count}, m3_cnt);
      do_pop  = ex_val && if3.outs_ready;
      do_push = ex_rdy && if3.ins_valid;
      if (do_pop) check("dut3_outs", if3.outs, m3_q.pop_front());
      if (do_push) m3_q.push_back(if3.ins);
      m3_cnt = m3_cnt + int'(do_push) - int'(do_pop);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    if4.ins = '0; if4.ins_valid = 1'b0; if4.outs_ready = 1'b0;
    if3.ins = '0; if3.ins_valid = 1'b0; if3.outs_ready = 1'b0;

    // 1: reset then single token
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("rst_ins_ready", {31'd0, if4.ins_ready}, 32'd0);
    check("rst_outs_valid", {31'd0, if4.outs_valid}, 32'd0);
    check("rst_count", {29'd0, if4.count}, 32'd0);
    check("rst_outs", if4.outs, 32'd0);
    tick();
    check("release_ins_ready", {31'd0, if4.ins_ready}, 32'd1);
    if4.ins = 32'h0058_1679; if4.ins_valid = 1'b1; if4.outs_ready = 1'b1;
    q4.push_back(32'h0058_1679);
    tick();
    if4.ins_valid = 1'b0;
    check("t1_count1", {29'd0, if4.count}, 32'd1);
    check("t1_valid", {31'd0, if4.outs_valid}, 32'd1);
    check("t1_ready", {31'd0, if4.ins_ready}, 32'd1);
    tick();
    check("t1_count0", {29'd0, if4.count}, 32'd0);
    check("t1_ready2", {31'd0, if4.ins_ready}, 32'd1);

    // 2: fill to full, extra token held, ins may wander while not ready
    if4.outs_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if4.ins = 32'(i * 'h11); if4.ins_valid = 1'b1;
      q4.push_back(32'(i * 'h11));
      tick();
    end
    check("t2_count_full", {29'd0, if4.count}, 32'd4);
    check("t2_ready_full", {31'd0, if4.ins_ready}, 32'd0);
    check("t2_head", if4.outs, 32'h11);
    if4.ins = 32'hDEAD_BEEF;
    tick();
    check("t2_count_hold", {29'd0, if4.count}, 32'd4);
    if4.ins = 32'h55;
    tick();
    check("t2_count_hold2", {29'd0, if4.count}, 32'd4);
    check("t2_head_hold", if4.outs, 32'h11);

    // 3: one-cycle pop, refill only next cycle, drain across the wrap
    if4.outs_ready = 1'b1;
    tick();
    if4.outs_ready = 1'b0;
    check("t3_count3", {29'd0, if4.count}, 32'd3);
    check("t3_ready_back", {31'd0, if4.ins_ready}, 32'd1);
    q4.push_back(32'h55);
    tick();
    if4.ins_valid = 1'b0;
    check("t3_count4", {29'd0, if4.count}, 32'd4);
    if4.outs_ready = 1'b1;
    repeat (4) tick();
    check("t3_count0", {29'd0, if4.count}, 32'd0);
    check("t3_empty", {31'd0, if4.outs_valid}, 32'd0);
    if4.outs_ready = 1'b0;

    // 4: streaming at count=2
    foreach (q4[i]) check("t4_q_empty", 32'd1, 32'd0);
    if4.ins_valid = 1'b1;
    if4.ins = 32'hA1; q4.push_back(32'hA1); tick();
    if4.ins = 32'hA2; q4.push_back(32'hA2); tick();
    check("t4_count2", {29'd0, if4.count}, 32'd2);
    if4.outs_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      if4.ins = 32'(i); q4.push_back(32'(i));
      tick();
      check("t4_count_steady", {29'd0, if4.count}, 32'd2);
    end
    if4.ins_valid = 1'b0;
    repeat (2) tick();
    check("t4_count0", {29'd0, if4.count}, 32'd0);
    if4.outs_ready = 1'b0;

    // 5: async reset mid-operation discards stored tokens
    if4.ins_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      if4.ins = 32'hB0 + 32'(i); q4.push_back(32'hB0 + 32'(i));
      tick();
    end
    if4.ins_valid = 1'b0;
    check("t5_count3", {29'd0, if4.count}, 32'd3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    q4.delete();
    check("t5_async_valid", {31'd0, if4.outs_valid}, 32'd0);
    check("t5_async_count", {29'd0, if4.count}, 32'd0);
    check("t5_async_ready", {31'd0, if4.ins_ready}, 32'd0);
    tick();
    rst = 1'b1;
    check("t5_rel_ready0", {31'd0, if4.ins_ready}, 32'd0);
    tick();
    check("t5_rel_ready1", {31'd0, if4.ins_ready}, 32'd1);
    check("t5_outs_clear", if4.outs, 32'd0);
    check("t5_valid_clear", {31'd0, if4.outs_valid}, 32'd0);

    // 6: random stress on DEPTH=3
    stress_on = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if3.ins_valid  = 1'($urandom_range(0, 1));
      if3.ins        = $urandom;
      if3.outs_ready = 1'($urandom_range(0, 1));
      tick();
    end
    if3.ins_valid  = 1'b0;
    if3.outs_ready = 1'b1;
    repeat (5) tick();
    stress_on = 1'b0;
    check("dut3_drained", m3_q.size(), 32'd0);
    check("dut4_drained", q4.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
